// File: rtl/vending_defs.sv
// rtl/vending_defs.sv - shared constants for the coin front end and vending state machine
package vending_defs;

   localparam int              CNT_W       = 20;
   localparam logic [CNT_W-1:0] CNT_MAX_DEF = 20'd999_999;
   localparam int              TALLY_W_DEF = 8;

   // Coin values in half-yuan units; the vending state machine reuses these.
   localparam logic [1:0] HALF = 2'd1;
   localparam logic [1:0] ONE  = 2'd2;

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - two-flop synchroniser, debounce counter and single detect strobe
module key_filter
   import vending_defs::*;
#(
   parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_n,
   output logic key_detect
);

   logic             sync1;
   logic             sync2;
   logic [1:0]       sync_vld;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // sync2 only carries a real sample two cycles after reset; a line held low
   // through reset must be seen released before a new press can count.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync_vld <= 2'b00;
         armed    <= 1'b0;
      end else begin
         sync_vld <= {sync_vld[0], 1'b1};
         if (sync_vld[1] && sync2)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         cnt <= '0;
      else if (sync2 || !armed)
         cnt <= '0;
      else if (cnt < CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   // Counter saturates at CNT_MAX, so this matches once per press.
   assign key_detect = armed && !sync2 && (cnt == CNT_MAX - 1'b1);

endmodule

// File: rtl/coin_pulse_gen.sv
// rtl/coin_pulse_gen.sv - debounced coin pulses, one-per-cycle arbitration and saturating tally
module coin_pulse_gen
   import vending_defs::*;
#(
   parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEF,
   parameter int               TALLY_W = TALLY_W_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               coin_half_n,
   input  logic               coin_one_n,
   output logic               pi_money_half,
   output logic               pi_money_one,
   output logic [TALLY_W-1:0] coin_tally
);

   logic det_half;
   logic det_one;
   logic pend_half;
   logic pend_one;
   logic pend_half_nxt;
   logic pend_one_nxt;
   logic half_nxt;
   logic one_nxt;
   logic half_req;
   logic one_req;

   key_filter #(.CNT_MAX(CNT_MAX)) u_half_filter (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_n      (coin_half_n),
      .key_detect (det_half)
   );

   key_filter #(.CNT_MAX(CNT_MAX)) u_one_filter (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_n      (coin_one_n),
      .key_detect (det_one)
   );

   // A pending half coin is older than any fresh one-strobe, so it goes first;
   // otherwise the one coin wins and the half waits a cycle.
   always_comb begin
      half_nxt      = 1'b0;
      one_nxt       = 1'b0;
      pend_half_nxt = 1'b0;
      pend_one_nxt  = 1'b0;
      half_req      = det_half | pend_half;
      one_req       = det_one | pend_one;
      if (pend_half) begin
         half_nxt      = 1'b1;
         pend_one_nxt  = one_req;
         pend_half_nxt = det_half;
      end else if (one_req) begin
         one_nxt       = 1'b1;
         pend_half_nxt = half_req;
      end else if (half_req) begin
         half_nxt      = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pi_money_half <= 1'b0;
         pi_money_one  <= 1'b0;
         pend_half     <= 1'b0;
         pend_one      <= 1'b0;
      end else begin
         pi_money_half <= half_nxt;
         pi_money_one  <= one_nxt;
         pend_half     <= pend_half_nxt;
         pend_one      <= pend_one_nxt;
      end
   end

   logic [1:0]       coin_val;
   logic [TALLY_W:0] tally_sum;

   always_comb begin
      coin_val = 2'd0;
      if (pi_money_one)
         coin_val = ONE;
      else if (pi_money_half)
         coin_val = HALF;
      tally_sum = {1'b0, coin_tally} + (TALLY_W+1)'(coin_val);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         coin_tally <= '0;
      else if (tally_sum[TALLY_W])
         coin_tally <= '1;
      else
         coin_tally <= tally_sum[TALLY_W-1:0];
   end

endmodule

// File: doc/coin_pulse_gen.md
Name: coin_pulse_gen

Overview:
Front-end coin acceptor for the cola vending controller. Takes two raw, bouncy, asynchronous coin-sensor lines (0.5 yuan and 1 yuan). It synchronises and debounces each line and emits clean single-cycle coin pulses. The vending state machine consumes these pulses directly as its money inputs. A running tally of accepted coins is also kept for debug and LED display.

Parameters:
CNT_MAX, 20'd999_999, debounce window in clock cycles minus one (20 ms at 50 MHz); the bench overrides this to 20'd19.
TALLY_W, 8, width of the accepted-value tally, counted in half-yuan units.

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  synchronous reset, active-high
coin_half_n  input  1  raw 0.5-yuan sensor; active-low; asynchronous and bouncy
coin_one_n  input  1  raw 1-yuan sensor; active-low; asynchronous and bouncy
pi_money_half  output  1  one-cycle pulse per accepted 0.5-yuan coin
pi_money_one  output  1  one-cycle pulse per accepted 1-yuan coin
coin_tally  output  TALLY_W  total accepted value in half-yuan units; saturating

Behaviour:
- Reset: one clock, synchronous and active-high (sys_rst=1 sampled on a rising edge of sys_clk).
  - While in reset, all outputs are 0, synchroniser flops preset to 1 (idle), debounce counters 0, pending flag 0.
  - Reset asserted mid-debounce abandons the coin: no pulse is emitted afterwards for that press.
- Synchronisation: each raw line passes through 2 flops before any logic sees it.
- Debounce, per channel (identical logic):
  - Synchronised line = 1 -> counter cleared to 0.
  - Synchronised line = 0 and counter < CNT_MAX -> counter += 1.
  - Counter == CNT_MAX -> counter holds.
  - A "detect" strobe fires in the single cycle where the counter equals CNT_MAX-1 and the line is still 0.
  - Exactly one strobe per press, however long the line stays low.
  - Any glitch to 1 before CNT_MAX-1 restarts the count; no strobe.
- Latency: the raw falling edge, held stable, produces its output pulse CNT_MAX+2 cycles later (±1 for synchroniser sampling phase).
- Output arbitration (never two pulses in the same cycle; the vending state machine takes one coin per cycle):
  - Only one channel strobes -> the matching pi_money_* is 1 for exactly the next cycle (registered).
  - Both strobe in the same cycle -> pi_money_one is emitted first, and a pending flag stores the half coin. pi_money_half is emitted the following cycle.
  - Half-coin pending and a new one-strobe arrives in the cycle the pending half is emitted -> the one pulse is deferred by one cycle. Pending depth is 1 per channel. A second same-channel strobe cannot occur within CNT_MAX cycles, so depth 1 is sufficient.
- Tally:
  - pi_money_half adds 1; pi_money_one adds 2.
  - Saturates at 2^TALLY_W-1; an add that would overflow clamps and does not wrap.
  - Reset clears it to 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header (vending_defs): CNT_MAX default, coin value constants (HALF=1, ONE=2 in half-yuan units), TALLY_W. The vending state machine reuses the coin value constants.
- One sub-module, key_filter: synchroniser + debounce counter + detect strobe, instantiated once per channel.
- The top level holds the arbitration, pending flags and tally.

Test Plan (CNT_MAX=19):
- Reset: assert sys_rst for 2 cycles with both raw lines 0 -> all outputs 0, tally 0. No pulse afterwards until the line is released to 1 and pressed again.
- Clean 1-yuan press: coin_one_n low for 40 cycles -> exactly one pi_money_one pulse, about 21 cycles after the falling edge; tally = 2.
- Bounce: coin_half_n toggles every 3 cycles for 30 cycles, then is held low 30 cycles -> exactly one pi_money_half, timed from the last falling edge; tally += 1.
- Short glitch: coin_one_n low for 10 cycles, then high -> no pulse, tally unchanged.
- Simultaneous: both lines fall on the same edge and are held 40 cycles -> pi_money_one in cycle N, pi_money_half in cycle N+1, never both high together; tally += 3.
- Saturation (TALLY_W=4): 8 one-yuan presses -> tally stops at 15, not 0.
